// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp_if
// Brief    : Decode read ports, writeback write ports and ready of reg_file_mp.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] d_srcA;
    logic [ADDR_W-1:0] d_srcB;
    logic [DATA_W-1:0] d_rvalA;
    logic [DATA_W-1:0] d_rvalB;
    logic [ADDR_W-1:0] W_dstE;
    logic [DATA_W-1:0] W_valE;
    logic [ADDR_W-1:0] W_dstM;
    logic [DATA_W-1:0] W_valM;
    logic              ready;

    modport master (
        output d_srcA, d_srcB, W_dstE, W_valE, W_dstM, W_valM,
        input  d_rvalA, d_rvalB, ready
    );

    modport slave (
        input  d_srcA, d_srcB, W_dstE, W_valE, W_dstM, W_valM,
        output d_rvalA, d_rvalB, ready
    );
endinterface
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Brief    : 2R/2W register file, write-through bypass, M-port priority and
//            sequential post-reset clear.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREG     = 32,
    parameter int RNONE    = 31,
    parameter int ZERO_REG = 1
) (
    input  wire logic    clk,
    input  wire logic    rst,
    reg_file_mp_if.slave bus
);

    localparam logic [ADDR_W-1:0] c_RNONE = ADDR_W'(RNONE);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(NREG - 1);
    localparam logic [ADDR_W:0]   c_NREG  = (ADDR_W + 1)'(NREG);

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_stateNext;
    logic [ADDR_W-1:0]   r_clrCnt;
    logic [ADDR_W-1:0]   w_clrCntNext;
    logic [DATA_W-1:0]   r_regs [NREG];
    logic                w_run;
    logic                w_weE;
    logic                w_weM;

    // An address names real storage only if it is not the "no register"
    // code, lies inside the implemented range and is not the hardwired zero.
    function automatic logic addrLive(input logic [ADDR_W-1:0] a);
        return (a != c_RNONE) && ({1'b0, a} < c_NREG) &&
               !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_run = (r_state == RUN);
    assign w_weE = w_run && addrLive(bus.W_dstE);
    assign w_weM = w_run && addrLive(bus.W_dstM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= CLEAR;
            r_clrCnt <= '0;
        end else begin
            r_state  <= w_stateNext;
            r_clrCnt <= w_clrCntNext;
        end
    end

    // The counter parks on the last index so it cannot wrap when NREG == 2^ADDR_W.
    always_comb begin
        w_stateNext  = r_state;
        w_clrCntNext = r_clrCnt;
        case (r_state)
            CLEAR: begin
                if (r_clrCnt == c_LAST) begin
                    w_stateNext = RUN;
                end else begin
                    w_clrCntNext = r_clrCnt + 1'b1;
                end
            end
            RUN:     w_stateNext = RUN;
            default: w_stateNext = CLEAR;
        endcase
    end

    // Storage has no reset; it is zeroed by the clear sequence. M is written
    // last so it wins a same-address conflict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == CLEAR) begin
                r_regs[r_clrCnt] <= '0;
            end else begin
                if (w_weE) r_regs[bus.W_dstE] <= bus.W_valE;
                if (w_weM) r_regs[bus.W_dstM] <= bus.W_valM;
            end
        end
    end

    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (!w_run || !addrLive(a)) begin
            v = '0;
        end else if (w_weM && (a == bus.W_dstM)) begin
            v = bus.W_valM;
        end else if (w_weE && (a == bus.W_dstE)) begin
            v = bus.W_valE;
        end else begin
            v = r_regs[a];
        end
        return v;
    endfunction

    assign bus.d_rvalA = readPort(bus.d_srcA);
    assign bus.d_rvalB = readPort(bus.d_srcB);
    assign bus.ready   = w_run;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_mp
// Brief    : Directed bench for reg_file_mp: default, ZERO_REG=0 and 16x16 builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_mp;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) bigIf ();
    reg_file_mp_if #(.DATA_W(32), .ADDR_W(5)) nzIf ();
    reg_file_mp_if #(.DATA_W(16), .ADDR_W(4)) smlIf ();

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NREG(32), .RNONE(31), .ZERO_REG(1)) u_big (
        .clk (clk),
        .rst (rst),
        .bus (bigIf.slave)
    );

    reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NREG(32), .RNONE(31), .ZERO_REG(0)) u_nz (
        .clk (clk),
        .rst (rst),
        .bus (nzIf.slave)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(4), .NREG(16), .RNONE(15), .ZERO_REG(1)) u_sml (
        .clk (clk),
        .rst (rst),
        .bus (smlIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic setBig(input logic [4:0] sa, input logic [4:0] sb,
                          input logic [4:0] de, input logic [31:0] ve,
                          input logic [4:0] dm, input logic [31:0] vm);
        bigIf.d_srcA = sa; bigIf.d_srcB = sb;
        bigIf.W_dstE = de; bigIf.W_valE = ve;
        bigIf.W_dstM = dm; bigIf.W_valM = vm;
        nzIf.d_srcA  = sa; nzIf.d_srcB  = sb;
        nzIf.W_dstE  = de; nzIf.W_valE  = ve;
        nzIf.W_dstM  = dm; nzIf.W_valM  = vm;
    endtask

    task automatic setSml(input logic [3:0] sa, input logic [3:0] sb,
                          input logic [3:0] de, input logic [15:0] ve,
                          input logic [3:0] dm, input logic [15:0] vm);
        smlIf.d_srcA = sa; smlIf.d_srcB = sb;
        smlIf.W_dstE = de; smlIf.W_valE = ve;
        smlIf.W_dstM = dm; smlIf.W_valM = vm;
    endtask

    // Called right after rst drops at a falling edge; counts rising edges to ready.
    task automatic waitReady(input int nWrite, input string tag);
        int eBig;
        int eNz;
        int eSml;
        eBig = 0;
        eNz  = 0;
        eSml = 0;
        if (nWrite > 0) begin
            setBig(5'd3, 5'd3, 5'd7, 32'h55, 5'd31, 32'h0);
            setSml(4'd3, 4'd3, 4'd7, 16'h55, 4'd15, 16'h0);
        end else begin
            setBig(5'd3, 5'd3, 5'd31, 32'h0, 5'd31, 32'h0);
            setSml(4'd3, 4'd3, 4'd15, 16'h0, 4'd15, 16'h0);
        end
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k == nWrite) begin
                setBig(5'd3, 5'd3, 5'd31, 32'h0, 5'd31, 32'h0);
                setSml(4'd3, 4'd3, 4'd15, 16'h0, 4'd15, 16'h0);
            end
            if (k == 3) begin
                check({tag, "_clrRdBigA"}, bigIf.d_rvalA, 32'h0);
                check({tag, "_clrRdNzB"}, nzIf.d_rvalB, 32'h0);
                check({tag, "_clrRdSmlA"}, 32'(smlIf.d_rvalA), 32'h0);
            end
            if (bigIf.ready && eBig == 0) eBig = k;
            if (nzIf.ready && eNz == 0) eNz = k;
            if (smlIf.ready && eSml == 0) eSml = k;
            if (eBig != 0 && eNz != 0 && eSml != 0) break;
        end
        check({tag, "_latBig"}, 32'(eBig), 32'd32);
        check({tag, "_latNz"}, 32'(eNz), 32'd32);
        check({tag, "_latSml"}, 32'(eSml), 32'd16);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        setBig(5'd3, 5'd3, 5'd31, 32'h0, 5'd31, 32'h0);
        setSml(4'd3, 4'd3, 4'd15, 16'h0, 4'd15, 16'h0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rstReadyBig", 32'(bigIf.ready), 32'h0);
        check("rstReadySml", 32'(smlIf.ready), 32'h0);
        check("rstRvalA", bigIf.d_rvalA, 32'h0);
        rst = 1'b0;
        waitReady(0, "clr1");

        // Basic write with same-cycle bypass, then registered read
        @(negedge clk);
        setBig(5'd4, 5'd3, 5'd3, 32'hDEADBEEF, 5'd31, 32'h0);
        setSml(4'd4, 4'd3, 4'd3, 16'hBEEF, 4'd15, 16'h0);
        #1;
        check("basicBypB", bigIf.d_rvalB, 32'hDEADBEEF);
        check("basicClearedA", bigIf.d_rvalA, 32'h0);
        check("basicSmlBypB", 32'(smlIf.d_rvalB), 32'h0000BEEF);
        @(negedge clk);
        setBig(5'd3, 5'd3, 5'd31, 32'h0, 5'd31, 32'h0);
        setSml(4'd3, 4'd3, 4'd15, 16'h0, 4'd15, 16'h0);
        #1;
        check("basicRegA", bigIf.d_rvalA, 32'hDEADBEEF);
        check("basicSmlRegA", 32'(smlIf.d_rvalA), 32'h0000BEEF);

        // Same-address conflict: M wins in bypass and in storage
        @(negedge clk);
        setBig(5'd5, 5'd5, 5'd5, 32'h1111, 5'd5, 32'h2222);
        setSml(4'd5, 4'd5, 4'd5, 16'h1111, 4'd5, 16'h2222);
        #1;
        check("confBypA", bigIf.d_rvalA, 32'h2222);
        check("confSmlBypA", 32'(smlIf.d_rvalA), 32'h2222);
        @(negedge clk);
        setBig(5'd5, 5'd5, 5'd31, 32'h0, 5'd31, 32'h0);
        setSml(4'd5, 4'd5, 4'd15, 16'h0, 4'd15, 16'h0);
        #1;
        check("confRegA", bigIf.d_rvalA, 32'h2222);
        check("confSmlRegB", 32'(smlIf.d_rvalB), 32'h2222);

        // E and M to different addresses: both land
        @(negedge clk);
        setBig(5'd8, 5'd9, 5'd8, 32'hAAAA0008, 5'd9, 32'hBBBB0009);
        #1;
        check("dualBypA", bigIf.d_rvalA, 32'hAAAA0008);
        check("dualBypB", bigIf.d_rvalB, 32'hBBBB0009);
        @(negedge clk);
        setBig(5'd8, 5'd9, 5'd31, 32'h0, 5'd31, 32'h0);
        #1;
        check("dualRegA", bigIf.d_rvalA, 32'hAAAA0008);
        check("dualRegB", bigIf.d_rvalB, 32'hBBBB0009);

        // Zero register and RNONE
        @(negedge clk);
        setBig(5'd0, 5'd31, 5'd0, 32'hFFFFFFFF, 5'd31, 32'hFFFFFFFF);
        setSml(4'd0, 4'd15, 4'd0, 16'hFFFF, 4'd15, 16'hFFFF);
        #1;
        check("zeroBypA", bigIf.d_rvalA, 32'h0);
        check("rnoneBypB", bigIf.d_rvalB, 32'h0);
        check("nzBypA", nzIf.d_rvalA, 32'hFFFFFFFF);
        check("nzRnoneBypB", nzIf.d_rvalB, 32'h0);
        check("smlZeroBypA", 32'(smlIf.d_rvalA), 32'h0);
        check("smlRnoneBypB", 32'(smlIf.d_rvalB), 32'h0);
        @(negedge clk);
        setBig(5'd0, 5'd31, 5'd31, 32'h0, 5'd31, 32'h0);
        setSml(4'd0, 4'd15, 4'd15, 16'h0, 4'd15, 16'h0);
        #1;
        check("zeroRegA", bigIf.d_rvalA, 32'h0);
        check("rnoneRegB", bigIf.d_rvalB, 32'h0);
        check("nzRegA", nzIf.d_rvalA, 32'hFFFFFFFF);
        check("nzRnoneRegB", nzIf.d_rvalB, 32'h0);
        check("smlZeroRegA", 32'(smlIf.d_rvalA), 32'h0);

        // Preload reg 7, reset, and hammer reg 7 during the clear
        @(negedge clk);
        setBig(5'd7, 5'd7, 5'd7, 32'h12345678, 5'd31, 32'h0);
        setSml(4'd7, 4'd7, 4'd7, 16'h1234, 4'd15, 16'h0);
        @(negedge clk);
        setBig(5'd7, 5'd7, 5'd31, 32'h0, 5'd31, 32'h0);
        setSml(4'd7, 4'd7, 4'd15, 16'h0, 4'd15, 16'h0);
        #1;
        check("preloadA", bigIf.d_rvalA, 32'h12345678);
        rst = 1'b1;
        @(negedge clk);
        check("rstMidRunReady", 32'(bigIf.ready), 32'h0);
        rst = 1'b0;
        waitReady(10, "clr2");
        @(negedge clk);
        setBig(5'd7, 5'd3, 5'd31, 32'h0, 5'd31, 32'h0);
        setSml(4'd7, 4'd3, 4'd15, 16'h0, 4'd15, 16'h0);
        #1;
        check("clrWr7Big", bigIf.d_rvalA, 32'h0);
        check("clrReg3Big", bigIf.d_rvalB, 32'h0);
        check("clrWr7Nz", nzIf.d_rvalA, 32'h0);
        check("clrWr7Sml", 32'(smlIf.d_rvalA), 32'h0);
        check("clrReg3Sml", 32'(smlIf.d_rvalB), 32'h0);

        // Reset again at clear index 12
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitReady(0, "midClr");

        // Small build still writes and reads after the restarted clear
        @(negedge clk);
        setSml(4'd2, 4'd2, 4'd2, 16'hA5A5, 4'd15, 16'h0);
        #1;
        check("smlPostBypA", 32'(smlIf.d_rvalA), 32'h0000A5A5);
        @(negedge clk);
        setSml(4'd2, 4'd2, 4'd15, 16'h0, 4'd15, 16'h0);
        #1;
        check("smlPostRegB", 32'(smlIf.d_rvalB), 32'h0000A5A5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised two-read/two-write register file with write-through bypass, writeback-port priority and a sequential post-reset clear sequencer. It sits between the decode stage (read ports) and the writeback stage (E and M write ports) of the pipelined core. It supersedes the fixed 16×32 file with generic width, depth, a configurable "no register" code and an optional hardwired-zero register.

## Interface
Parameters:
- DATA_W, 32, data width of every register and port.
- ADDR_W, 5, register address width.
- NREG, 32, number of implemented registers, ≤ 2^ADDR_W.
- RNONE, 31, address code meaning "no register"; never written, reads as 0.
- ZERO_REG, 1, if 1, register 0 is hardwired to 0 and writes to it are dropped.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- d_srcA  in  ADDR_W  read address A.
- d_srcB  in  ADDR_W  read address B.
- d_rvalA  out  DATA_W  read data A (combinational).
- d_rvalB  out  DATA_W  read data B (combinational).
- W_dstE  in  ADDR_W  write address, E port; RNONE = no write.
- W_valE  in  DATA_W  write data, E port.
- W_dstM  in  ADDR_W  write address, M port; RNONE = no write.
- W_valM  in  DATA_W  write data, M port.
- ready  out  1  1 = clear sequence done, file accepts writes.

## Operation
- States: CLEAR, RUN. Clear counter clr_cnt, ADDR_W bits.
- rst=1 at an edge: state←CLEAR, clr_cnt←0, ready←0. Register contents are not touched by rst itself.
- CLEAR, rst=0: regs[clr_cnt]←0, clr_cnt←clr_cnt+1. The edge that clears index NREG-1 sets state←RUN and ready←1. The counter never wraps.
- In CLEAR, both write ports are ignored and d_rvalA/d_rvalB read 0.
- RUN: on each edge, a port with dst ≠ RNONE, dst < NREG, and not (ZERO_REG && dst==0) writes its val.
- Same-edge conflict, W_dstE == W_dstM and valid: M wins. E and M to different addresses: both are written.
- Reads in RUN, per port, in priority order:
  - addr==RNONE, addr≥NREG, or (ZERO_REG && addr==0) → 0.
  - addr==W_dstM and M valid → W_valM (bypass).
  - addr==W_dstE and E valid → W_valE (bypass).
  - else regs[addr].
- A write to an out-of-range address (≥NREG, ≠RNONE) is silently dropped.
- rst asserted mid-CLEAR or mid-RUN: restart CLEAR from index 0 on the next rst=0 edge. Contents persist until overwritten by the sequence.

## Timing
- Reset values: ready=0, state=CLEAR, clr_cnt=0. d_rvalA and d_rvalB read 0 while ready=0.
- Clear latency: ready rises on the NREG-th rising edge after rst deasserts (default 32 edges).
- Write latency: a write is visible in regs after the edge where it is presented. Through the bypass it is visible on d_rval in the same cycle, with combinational path W_* → d_rval*.
- Read latency: 0 cycles, combinational from d_src*, W_dst*, W_val* and register state.
- No handshake on write ports. The pipeline must hold writeback while ready=0.

## Test plan
- Reset/clear: pre-load via RUN, assert rst 1 cycle, release → ready=0 for exactly 31 edges and 1 after the 32nd; all 32 reads (except RNONE) return 0 afterwards.
- Basic write/read: in RUN, W_dstE=3, W_valE=32'hDEADBEEF for one cycle, then d_srcA=3 → d_rvalA=32'hDEADBEEF. During the write cycle with d_srcB=3 → d_rvalB=32'hDEADBEEF via bypass.
- Conflict: W_dstE=W_dstM=5, valE=32'h1111, valM=32'h2222 → same-cycle read of 5 gives 32'h2222; after the edge, regs[5]=32'h2222.
- Zero/RNONE: write 32'hFFFF_FFFF to dst 0 and dst 31 → reads of 0 and 31 return 0, both same cycle and later. With ZERO_REG=0, reg 0 reads 32'hFFFF_FFFF.
- Writes during CLEAR: drive W_dstE=7, valE=32'h55 during cycles 1–10 after reset → after ready=1, regs[7]=0.
- Reset mid-clear plus parameter sweep: assert rst at clear index 12 → ready rises 32 edges after re-release. Repeat with DATA_W=16, ADDR_W=4, NREG=16, RNONE=15 → ready after 16 edges, and basic write/read passes.
